// File: rtl/agc_pkg.sv
// Shared widths, unity-gain and output-limit constants, plus clamp/saturate helpers
// for the AGC gain-apply datapath.
package agc_pkg;

    localparam int unsigned DWIDTH_DEF   = 16;
    localparam int unsigned OWIDTH_DEF   = 16;
    localparam int unsigned GINWIDTH_DEF = 48;
    localparam int unsigned GSHIFT_DEF   = 20;
    localparam int unsigned GBITS_DEF    = 18;
    localparam int unsigned GFRAC_DEF    = 12;
    localparam int unsigned MWIDTH_DEF   = 30;

    localparam int UNITY_GAIN = 1 << GFRAC_DEF;
    localparam int OUT_MAX    = (1 << (OWIDTH_DEF - 1)) - 1;
    localparam int OUT_MIN    = -OUT_MAX;

    // Limit a gain value to [0, 2^bits-1].
    function automatic logic signed [63:0] clamp_gain(input logic signed [63:0] x,
                                                      input int unsigned bits);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< bits) - 64'sd1;
        if (x < 64'sd0) return 64'sd0;
        if (x > lim) return lim;
        return x;
    endfunction

    // Symmetric clip to +/-(2^(w-1)-1).
    function automatic logic signed [63:0] sat_sym(input logic signed [63:0] x,
                                                   input int unsigned w);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (x > lim) return lim;
        if (x < -lim) return -lim;
        return x;
    endfunction

    function automatic logic is_clip(input logic signed [63:0] x, input int unsigned w);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (w - 1)) - 64'sd1;
        return (x > lim) || (x < -lim);
    endfunction

endpackage

// File: rtl/agc_gain_apply_if.sv
// Gain, sample and levelled-output signals of the AGC gain-apply stage.
// Sat_Count exists only when AGC_SAT_COUNT_EN is defined.
interface agc_gain_apply_if
    import agc_pkg::*;
#(
    parameter int unsigned DWIDTH   = DWIDTH_DEF,
    parameter int unsigned OWIDTH   = OWIDTH_DEF,
    parameter int unsigned GINWIDTH = GINWIDTH_DEF,
    parameter int unsigned MWIDTH   = MWIDTH_DEF
);
    logic signed [GINWIDTH-1:0] Gain_In;
    logic                       Gain_Valid;
    logic signed [DWIDTH-1:0]   Data_I;
    logic signed [DWIDTH-1:0]   Data_Q;
    logic                       Data_Valid;
    logic signed [OWIDTH-1:0]   Data_Out_I;
    logic signed [OWIDTH-1:0]   Data_Out_Q;
    logic                       Valid_out;
    logic                       Sat_Flag;
    logic [MWIDTH-1:0]          Mag_Out;
    logic                       Mag_Valid;
`ifdef AGC_SAT_COUNT_EN
    logic [15:0]                Sat_Count;
`endif

    modport master (
        output Gain_In, Gain_Valid, Data_I, Data_Q, Data_Valid,
        input  Data_Out_I, Data_Out_Q, Valid_out, Sat_Flag, Mag_Out, Mag_Valid
`ifdef AGC_SAT_COUNT_EN
        , input Sat_Count
`endif
    );

    modport slave (
        input  Gain_In, Gain_Valid, Data_I, Data_Q, Data_Valid,
        output Data_Out_I, Data_Out_Q, Valid_out, Sat_Flag, Mag_Out, Mag_Valid
`ifdef AGC_SAT_COUNT_EN
        , output Sat_Count
`endif
    );

endinterface

// File: rtl/agc_round_sat.sv
// One channel of the output stage: round-half-up, drop GFRAC fraction bits, clip
// symmetrically to OWIDTH and flag the clip.
module agc_round_sat
    import agc_pkg::*;
#(
    parameter int unsigned PWIDTH = DWIDTH_DEF + GBITS_DEF + 1,
    parameter int unsigned OWIDTH = OWIDTH_DEF,
    parameter int unsigned GFRAC  = GFRAC_DEF
) (
    input  logic signed [PWIDTH-1:0] i_prod,
    output logic signed [OWIDTH-1:0] o_data,
    output logic                     o_sat
);

    logic signed [63:0] w_ext;
    logic signed [63:0] w_rnd;

    always_comb begin
        w_ext  = {{(64 - PWIDTH){i_prod[PWIDTH-1]}}, i_prod};
        w_rnd  = (w_ext + (64'sd1 <<< (GFRAC - 1))) >>> GFRAC;
        o_data = OWIDTH'(sat_sym(w_rnd, OWIDTH));
        o_sat  = is_clip(w_rnd, OWIDTH);
    end

endmodule

// File: rtl/agc_gain_apply.sv
// AGC gain apply: clamps the accumulated gain word and scales the I/Q stream through a
// 3-stage pipeline, then forms |I|+|Q|. AGC_SAT_COUNT_EN adds a saturating clip counter.
module agc_gain_apply
    import agc_pkg::*;
#(
    parameter int unsigned DWIDTH   = DWIDTH_DEF,
    parameter int unsigned OWIDTH   = OWIDTH_DEF,
    parameter int unsigned GINWIDTH = GINWIDTH_DEF,
    parameter int unsigned GSHIFT   = GSHIFT_DEF,
    parameter int unsigned GBITS    = GBITS_DEF,
    parameter int unsigned GFRAC    = GFRAC_DEF,
    parameter int unsigned MWIDTH   = MWIDTH_DEF
) (
    input logic             clk,
    input logic             rst_n,
    agc_gain_apply_if.slave bus
);

    localparam int unsigned PWIDTH = DWIDTH + GBITS + 1;
    localparam logic [GBITS-1:0] UNITY = GBITS'(1) << GFRAC;

    logic signed [63:0]       w_gin64;
    logic signed [63:0]       w_g64;
    logic [GBITS-1:0]         r_gain;

    logic                     r_s1_vld;
    logic signed [DWIDTH-1:0] r_s1_i;
    logic signed [DWIDTH-1:0] r_s1_q;
    logic [GBITS-1:0]         r_s1_gain;

    logic signed [PWIDTH-1:0] w_i_ext;
    logic signed [PWIDTH-1:0] w_q_ext;
    logic signed [PWIDTH-1:0] w_g_ext;
    logic                     r_s2_vld;
    logic signed [PWIDTH-1:0] r_s2_pi;
    logic signed [PWIDTH-1:0] r_s2_pq;

    logic signed [OWIDTH-1:0] w_rs_i;
    logic signed [OWIDTH-1:0] w_rs_q;
    logic                     w_sat_i;
    logic                     w_sat_q;
    logic                     r_vld3;
    logic signed [OWIDTH-1:0] r_out_i;
    logic signed [OWIDTH-1:0] r_out_q;
    logic                     r_sat;

    logic [OWIDTH-1:0]        w_abs_i;
    logic [OWIDTH-1:0]        w_abs_q;
    logic [MWIDTH-1:0]        w_mag;
    logic                     r_mag_vld;
    logic [MWIDTH-1:0]        r_mag;

    assign w_gin64 = {{(64 - GINWIDTH){bus.Gain_In[GINWIDTH-1]}}, bus.Gain_In};
    assign w_g64   = w_gin64 >>> GSHIFT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gain <= UNITY;
        end else if (bus.Gain_Valid) begin
            r_gain <= GBITS'(clamp_gain(w_g64, GBITS));
        end
    end

    // S1 snapshots the pre-update gain, so a same-cycle gain load applies to the next sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_i    <= '0;
            r_s1_q    <= '0;
            r_s1_gain <= UNITY;
        end else begin
            r_s1_vld  <= bus.Data_Valid;
            r_s1_i    <= bus.Data_I;
            r_s1_q    <= bus.Data_Q;
            r_s1_gain <= r_gain;
        end
    end

    assign w_i_ext = {{(PWIDTH - DWIDTH){r_s1_i[DWIDTH-1]}}, r_s1_i};
    assign w_q_ext = {{(PWIDTH - DWIDTH){r_s1_q[DWIDTH-1]}}, r_s1_q};
    assign w_g_ext = $signed(PWIDTH'(r_s1_gain));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_s2_pi  <= '0;
            r_s2_pq  <= '0;
        end else begin
            r_s2_vld <= r_s1_vld;
            r_s2_pi  <= w_i_ext * w_g_ext;
            r_s2_pq  <= w_q_ext * w_g_ext;
        end
    end

    agc_round_sat #(
        .PWIDTH (PWIDTH),
        .OWIDTH (OWIDTH),
        .GFRAC  (GFRAC)
    ) u_round_sat_i (
        .i_prod (r_s2_pi),
        .o_data (w_rs_i),
        .o_sat  (w_sat_i)
    );

    agc_round_sat #(
        .PWIDTH (PWIDTH),
        .OWIDTH (OWIDTH),
        .GFRAC  (GFRAC)
    ) u_round_sat_q (
        .i_prod (r_s2_pq),
        .o_data (w_rs_q),
        .o_sat  (w_sat_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld3  <= 1'b0;
            r_out_i <= '0;
            r_out_q <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_vld3 <= r_s2_vld;
            if (r_s2_vld) begin
                r_out_i <= w_rs_i;
                r_out_q <= w_rs_q;
                r_sat   <= w_sat_i | w_sat_q;
            end
        end
    end

    // Outputs are clipped symmetrically, so negation never overflows.
    always_comb begin
        w_abs_i = r_out_i[OWIDTH-1] ? -r_out_i : r_out_i;
        w_abs_q = r_out_q[OWIDTH-1] ? -r_out_q : r_out_q;
        w_mag   = MWIDTH'(w_abs_i) + MWIDTH'(w_abs_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mag_vld <= 1'b0;
            r_mag     <= '0;
        end else begin
            r_mag_vld <= r_vld3;
            if (r_vld3) begin
                r_mag <= w_mag;
            end
        end
    end

`ifdef AGC_SAT_COUNT_EN
    logic [15:0] r_sat_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (r_vld3 && r_sat && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign bus.Sat_Count = r_sat_cnt;
`endif

    assign bus.Data_Out_I = r_out_i;
    assign bus.Data_Out_Q = r_out_q;
    assign bus.Valid_out  = r_vld3;
    assign bus.Sat_Flag   = r_sat;
    assign bus.Mag_Out    = r_mag;
    assign bus.Mag_Valid  = r_mag_vld;

endmodule

// File: tb/tb_agc_gain_apply.sv
// Directed bench for agc_gain_apply: vector table for gain/rounding/clip cases plus
// sequences for same-cycle gain update, mid-stream reset, bursts and the clip counter.
module tb_agc_gain_apply;
    import agc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    agc_gain_apply_if bus_if ();

    agc_gain_apply dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic               gv;
        logic [47:0]        gain;
        logic signed [15:0] di;
        logic signed [15:0] dq;
        logic signed [15:0] ei;
        logic signed [15:0] eq;
        logic               esat;
        logic [29:0]        emag;
    } vec_t;

    vec_t vecs[10];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic gv, input logic [47:0] gain,
                                input int di, input int dq, input int ei, input int eq,
                                input logic esat, input int emag);
        vec_t v;
        v.gv = gv; v.gain = gain;
        v.di = 16'(di); v.dq = 16'(dq); v.ei = 16'(ei); v.eq = 16'(eq);
        v.esat = esat; v.emag = 30'(emag);
        return v;
    endfunction

    task automatic load_gain(input logic [47:0] g);
        @(negedge clk);
        bus_if.Gain_Valid = 1'b1;
        bus_if.Gain_In    = g;
        @(negedge clk);
        bus_if.Gain_Valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        string t;
        t = $sformatf("v%0d", k);
        if (v.gv) load_gain(v.gain);
        else @(negedge clk);
        bus_if.Data_I = v.di;
        bus_if.Data_Q = v.dq;
        bus_if.Data_Valid = 1'b1;
        @(negedge clk);
        bus_if.Data_Valid = 1'b0;
        @(negedge clk);
        chk({t, "_vld_early"}, bus_if.Valid_out, 0);
        @(negedge clk);
        chk({t, "_vld"}, bus_if.Valid_out, 1);
        chk({t, "_i"}, bus_if.Data_Out_I, v.ei);
        chk({t, "_q"}, bus_if.Data_Out_Q, v.eq);
        chk({t, "_sat"}, bus_if.Sat_Flag, v.esat);
        @(negedge clk);
        chk({t, "_vld_single"}, bus_if.Valid_out, 0);
        chk({t, "_mvld"}, bus_if.Mag_Valid, 1);
        chk({t, "_mag"}, bus_if.Mag_Out, v.emag);
        @(negedge clk);
        chk({t, "_mvld_single"}, bus_if.Mag_Valid, 0);
        chk({t, "_i_hold"}, bus_if.Data_Out_I, v.ei);
    endtask

    initial begin
        int nv;
        int nm;
        int first;
        int last;

        vecs[0] = mk(0, 48'd0, 1000, -500, 1000, -500, 0, 1500);
        vecs[1] = mk(1, 48'd8192 << 20, 1000, 0, 2000, 0, 0, 2000);
        vecs[2] = mk(1, 48'd16384 << 20, 10000, 0, 32767, 0, 1, 32767);
        vecs[3] = mk(0, 48'd0, -10000, 0, -32767, 0, 1, 32767);
        vecs[4] = mk(0, 48'd0, -32768, 32767, -32767, 32767, 1, 65534);
        vecs[5] = mk(1, 48'd6144 << 20, 3, -3, 5, -4, 0, 9);
        vecs[6] = mk(0, 48'd0, 1, -1, 2, -1, 0, 3);
        vecs[7] = mk(0, 48'd0, -32768, 0, -32767, 0, 1, 32767);
        vecs[8] = mk(1, 48'hFFFF_FFFF_FFFF, 1000, -1000, 0, 0, 0, 0);
        vecs[9] = mk(1, 48'h7FFF_FFFF_FFFF, 1, -1, 64, -64, 0, 128);

        bus_if.Gain_In = '0;
        bus_if.Gain_Valid = 1'b0;
        bus_if.Data_I = '0;
        bus_if.Data_Q = '0;
        bus_if.Data_Valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_vld", bus_if.Valid_out, 0);
        chk("rst_mvld", bus_if.Mag_Valid, 0);
        chk("rst_i", bus_if.Data_Out_I, 0);
        chk("rst_q", bus_if.Data_Out_Q, 0);
        chk("rst_sat", bus_if.Sat_Flag, 0);
        chk("rst_mag", bus_if.Mag_Out, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

        // Two samples in flight when reset hits; neither may emerge.
        load_gain(48'd16384 << 20);
        bus_if.Data_I = 16'sd1000;
        bus_if.Data_Q = 16'sd0;
        bus_if.Data_Valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_if.Data_Valid = 1'b0;
        rst_n = 1'b0;
        nv = 0;
        nm = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (t == 1) rst_n = 1'b1;
            nv += int'(bus_if.Valid_out);
            nm += int'(bus_if.Mag_Valid);
        end
        chk("rstmid_vld_cnt", nv, 0);
        chk("rstmid_mvld_cnt", nm, 0);
        chk("rstmid_i", bus_if.Data_Out_I, 0);

        // Same-cycle gain load: first sample sees unity, second sees 2.0.
        @(negedge clk);
        bus_if.Gain_Valid = 1'b1;
        bus_if.Gain_In = 48'd8192 << 20;
        bus_if.Data_I = 16'sd100;
        bus_if.Data_Valid = 1'b1;
        @(negedge clk);
        bus_if.Gain_Valid = 1'b0;
        @(negedge clk);
        bus_if.Data_Valid = 1'b0;
        @(negedge clk);
        chk("same_vld0", bus_if.Valid_out, 1);
        chk("same_i0", bus_if.Data_Out_I, 100);
        @(negedge clk);
        chk("same_vld1", bus_if.Valid_out, 1);
        chk("same_i1", bus_if.Data_Out_I, 200);
        repeat (3) @(negedge clk);

        // 8-sample burst at G=2.0: observe, then drive, on each falling edge.
        nv = 0;
        nm = 0;
        first = -1;
        last = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus_if.Valid_out) begin
                chk($sformatf("burst_i%0d", nv), bus_if.Data_Out_I, 200 * (nv + 1));
                nv++;
                if (first < 0) first = t;
                last = t;
            end
            nm += int'(bus_if.Mag_Valid);
            bus_if.Data_Valid = (t < 8);
            bus_if.Data_I = 16'((t + 1) * 100);
        end
        chk("burst_cnt", nv, 8);
        chk("burst_first", first, 3);
        chk("burst_span", last - first, 7);
        chk("burst_mcnt", nm, 8);

`ifdef AGC_SAT_COUNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("satcnt_rst", bus_if.Sat_Count, 0);
        load_gain(48'd16384 << 20);
        for (int t = 0; t < 4; t++) begin
            bus_if.Data_I = (t == 2) ? 16'sd10 : 16'sd10000;
            bus_if.Data_Valid = 1'b1;
            @(negedge clk);
        end
        bus_if.Data_Valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("satcnt", bus_if.Sat_Count, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
